// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
package nn_pkg;

  // Width of the scratch arithmetic used by sat_add; element widths up to SAT_W-1.
  localparam int unsigned SAT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } pp_state_t;

  // Clamp a sign-extended sum to the signed range of a width-bit element.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] sum,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/elem_postproc.sv
// Combinational per-element post-processing: bias add, saturation, optional ReLU.
module elem_postproc
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] bias,
  output logic [WIDTH-1:0] elem
);

  logic signed [WIDTH:0]   sum;
  logic signed [SAT_W-1:0] sat;

  // Full-precision add, clamp to element range, then clamp negatives when ReLU is on.
  always_comb begin
    sum  = $signed({result[WIDTH-1], result}) + $signed({bias[WIDTH-1], bias});
    sat  = sat_add({{(SAT_W - WIDTH - 1){sum[WIDTH]}}, sum}, WIDTH);
    elem = sat[WIDTH-1:0];
    if (RELU_EN && (sat < 0)) begin
      elem = '0;
    end
  end

endmodule

// File: rtl/mvm_postproc.sv
// Output stage after the matrix-vector multiplier: captures the result vector,
// applies per-row bias/saturation/ReLU and streams the rows over valid/ready.
module mvm_postproc
  import nn_pkg::*;
#(
  parameter int unsigned MATRIX_ROWS = 3,
  parameter int unsigned WIDTH       = 8,
  parameter bit          RELU_EN     = 1'b1,
  localparam int unsigned IDX_W      = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         capture,
  input  logic [MATRIX_ROWS*WIDTH-1:0] result_vector,
  input  logic [MATRIX_ROWS*WIDTH-1:0] bias_vector,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [IDX_W-1:0]             out_index,
  output logic                         out_last,
  output logic                         done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ROWS - 1);

  pp_state_t        state;
  logic [IDX_W-1:0] index;
  logic [WIDTH-1:0] proc   [MATRIX_ROWS];
  logic [WIDTH-1:0] buffer [MATRIX_ROWS];

  // One processing lane per row; row 0 sits in the most significant slice.
  for (genvar g = 0; g < MATRIX_ROWS; g++) begin : g_lane
    elem_postproc #(
      .WIDTH  (WIDTH),
      .RELU_EN(RELU_EN)
    ) u_elem (
      .result(result_vector[(MATRIX_ROWS - g) * WIDTH - 1 -: WIDTH]),
      .bias  (bias_vector[(MATRIX_ROWS - g) * WIDTH - 1 -: WIDTH]),
      .elem  (proc[g])
    );
  end

  assign out_index = index;
  assign out_data  = buffer[index];

  // Capture/stream/done sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < MATRIX_ROWS; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            for (int unsigned i = 0; i < MATRIX_ROWS; i++) begin
              buffer[i] <= proc[i];
            end
            index     <= '0;
            state     <= STREAM;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == '0);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (index == LAST_IDX) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              index    <= index + IDX_W'(1);
              out_last <= ((index + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mvm_postproc.md
# mvm_postproc

Output stage directly downstream of the matrix-vector multiplier (`mvm`). It captures the flattened `result_vector` once the multiply has settled and adds a per-row signed bias with saturation. It then optionally applies ReLU and streams the processed elements, one per cycle, over a valid/ready handshake to the next layer's loader. Capture is triggered by a single-cycle pulse from the layer controller.

## Interface
Parameters:
- `MATRIX_ROWS`, 3: number of elements in `result_vector`.
- `WIDTH`, 8: element width, signed two's complement.
- `RELU_EN`, 1: 1 clamps negative results to 0; 0 passes saturated sums through.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `capture`  in  1: pulse; sample `result_vector` and `bias_vector`.
- `result_vector`  in  MATRIX_ROWS*WIDTH: mvm output; row 0 occupies bits [MATRIX_ROWS*WIDTH-1 -: WIDTH].
- `bias_vector`  in  MATRIX_ROWS*WIDTH: per-row signed bias, same packing.
- `busy`  out  1: high from the capture-accept cycle+1 until the last transfer completes.
- `out_valid`  out  1: `out_data` holds a valid element.
- `out_ready`  in  1: downstream accepts the element.
- `out_data`  out  WIDTH: processed element.
- `out_index`  out  $clog2(MATRIX_ROWS) (min 1): row index of `out_data`.
- `out_last`  out  1: high with the final element (index MATRIX_ROWS-1).
- `done`  out  1: one-cycle pulse after the last transfer.

## Operation
- Per element: sum = sext(r) + sext(b) in WIDTH+1 bits.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If RELU_EN, negative values become 0.
- All MATRIX_ROWS elements are computed combinationally at capture and registered into an internal buffer.
- FSM:
  - IDLE: `capture`=1 loads the buffer, clears the index and goes to STREAM.
  - STREAM: `out_valid`=1. On transfer (`out_valid && out_ready`), if the index is MATRIX_ROWS-1, go to DONE; otherwise increment the index.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- `capture` is honoured only in IDLE. It is ignored in STREAM and DONE, including when it coincides with the last transfer.
- The inputs are sampled only on the capture cycle. Later changes on `result_vector` and `bias_vector` have no effect on the current stream.

## Timing
- Reset (asynchronous) values: state=IDLE, buffer=0, `busy`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `done`=0.
- Capture in cycle N:
  - `out_valid`=1 and row 0 appear in cycle N+1 (latency 1).
  - With `out_ready` held high, rows stream in cycles N+1 .. N+MATRIX_ROWS.
  - `done` is high in cycle N+MATRIX_ROWS+1.
  - The next capture is accepted in cycle N+MATRIX_ROWS+2 or later.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable. `out_valid` never drops before its transfer.
- `out_data`, `out_index` and `out_last` are driven from registers or buffer muxes on the registered index. There is no combinational path from `out_ready` to `out_valid`.
- Reset asserted mid-stream: everything returns immediately to its reset values and no `done` is issued. The first capture after reset is processed normally.

## Structure
- Shared package `nn_pkg`:
  - `sat_add` function (signed WIDTH+1 to WIDTH saturation).
  - FSM state enum {IDLE, STREAM, DONE}.
- Sub-module `elem_postproc` (combinational: bias add, saturate, ReLU), instantiated MATRIX_ROWS times via generate.
- The top level holds the FSM, index counter and buffer.

## Test plan
All scenarios use defaults unless stated.
- Basic:
  - Stimulus: result 0E2032, bias 020304, capture, `out_ready`=1.
  - Required: stream 10, 23, 36 at indices 0, 1, 2; `out_last` only on 36; `done` one cycle later.
- ReLU:
  - Stimulus: result A7D4FB, bias 000000.
  - Required: stream 00, 00, 00 with RELU_EN=1; stream A7, D4, FB with RELU_EN=0.
- Saturation:
  - Stimulus: result 7F6080, bias 017FFF.
  - Required with RELU_EN=1: 7F, 7F, 00. Required with RELU_EN=0: 7F, 7F, 80.
- Backpressure:
  - Stimulus: basic vectors; `out_ready` low for 4 cycles while index=1.
  - Required: `out_data`=23, index=1 and `out_valid`=1 hold throughout; 36 follows on the cycle after `out_ready` rises.
- Busy/ignore:
  - Stimulus: second capture with different data at index 1, and again coincident with the last transfer.
  - Required: both ignored; the original stream completes unchanged.
- Reset mid-stream:
  - Stimulus: assert reset while index=1.
  - Required: all outputs 0 within the same cycle and no `done`; a following capture of the basic vectors yields 10, 23, 36.
